// File: rtl/amp_channel_scheduler.sv
// Time-shared scale-and-gain datapath for a bank of FIR channels: per-channel capture,
// round-robin grant, two-stage shift/multiply pipeline, per-channel output registers.
module amp_channel_scheduler #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DW     = 32,
    parameter int unsigned OW     = 16,
    parameter int unsigned CW     = 3,
    parameter int unsigned SHIFT  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_data,
    input  logic [NUM_CH*CW-1:0] amp_coef,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [NUM_CH*OW-1:0] out_data,
    output logic [NUM_CH-1:0]    overrun,
    output logic                 busy
);

    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [NUM_CH-1:0]    overrun_q, overrun_d;
    logic [DW-1:0]        hold_q [NUM_CH];
    logic [DW-1:0]        hold_d [NUM_CH];
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 s1_val_q, s1_val_d;
    logic [PW-1:0]        s1_ch_q, s1_ch_d;
    logic [DW-1:0]        s1_data_q, s1_data_d;
    logic [CW-1:0]        s1_coef_q, s1_coef_d;
    logic [NUM_CH-1:0]    out_valid_q, out_valid_d;
    logic [NUM_CH*OW-1:0] out_data_q, out_data_d;
    logic                 busy_q, busy_d;

    logic                 gnt_vld;
    logic [PW-1:0]        gnt_ch;
    logic [PW-1:0]        scan_idx;

    // Round-robin arbiter: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan_idx = rr_ptr_q + PW'(i);
            if (enable && !gnt_vld && pending_q[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = scan_idx;
            end
        end
    end

    // Capture: a granted channel reads its old hold value while a same-cycle post refills it.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        hold_d    = hold_q;
        if (gnt_vld) begin
            pending_d[gnt_ch] = 1'b0;
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (in_valid[c]) begin
                hold_d[c]    = in_data[c*DW +: DW];
                pending_d[c] = 1'b1;
                if (pending_q[c] && !(gnt_vld && gnt_ch == PW'(c))) begin
                    overrun_d[c] = 1'b1;
                end
            end
        end
    end

    // Pipeline: stage 1 scales the granted sample, stage 2 applies gain and writes the channel slot.
    always_comb begin
        s1_val_d  = gnt_vld;
        s1_ch_d   = s1_ch_q;
        s1_data_d = s1_data_q;
        s1_coef_d = s1_coef_q;
        if (gnt_vld) begin
            s1_ch_d   = gnt_ch;
            s1_data_d = DW'($signed(hold_q[gnt_ch]) >>> SHIFT);
            s1_coef_d = amp_coef[gnt_ch*CW +: CW];
        end

        out_valid_d = '0;
        out_data_d  = out_data_q;
        if (s1_val_q) begin
            out_valid_d[s1_ch_q]           = 1'b1;
            out_data_d[s1_ch_q*OW +: OW]   = OW'($signed(s1_data_q) * $signed(DW'(s1_coef_q)));
        end

        rr_ptr_d = gnt_vld ? (gnt_ch + PW'(1)) : rr_ptr_q;
        busy_d   = (|pending_d) | s1_val_d | (|out_valid_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
            end
            rr_ptr_q    <= '0;
            s1_val_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_data_q   <= '0;
            s1_coef_q   <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
            s1_val_q    <= s1_val_d;
            s1_ch_q     <= s1_ch_d;
            s1_data_q   <= s1_data_d;
            s1_coef_q   <= s1_coef_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
